// File: rtl/des_stream_pkg.sv
// Shared constants and types for the DES plaintext stream path.
package des_stream_pkg;

  localparam int unsigned BLOCK_BYTES = 8;
  localparam int unsigned BLOCK_W     = 64;

  localparam bit PAD_PKCS = 1'b1;
  localparam bit PAD_ZERO = 1'b0;

  localparam logic [BLOCK_W-1:0] PKCS_FULL_BLOCK = 64'h0808080808080808;

  typedef enum logic [1:0] {
    S_FILL,
    S_HOLD,
    S_EXTRA
  } state_e;

endpackage

// File: rtl/des_pad_fill.sv
// Pads every byte after last_idx_i with the PKCS#7 pad count or zero.
module des_pad_fill
  import des_stream_pkg::*;
(
  input  logic [BLOCK_W-1:0] block_i,
  input  logic [2:0]         last_idx_i,
  input  logic               pad_mode_i,
  output logic [BLOCK_W-1:0] block_o
);

  logic [7:0] pad_byte;

  always_comb begin
    block_o  = block_i;
    // Pad count is the number of bytes after last_idx_i, i.e. 7 - last_idx_i.
    pad_byte = pad_mode_i ? {5'b0, 3'd7 - last_idx_i} : 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (j > int'(last_idx_i)) begin
        block_o[BLOCK_W-1-8*j -: 8] = pad_byte;
      end
    end
  end

endmodule

// File: rtl/des_block_packer.sv
// Packs an MSB-first byte stream into padded 64-bit blocks for the DES stage.
module des_block_packer
  import des_stream_pkg::*;
#(
  parameter bit PAD_MODE = PAD_PKCS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [7:0]         data_in,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] data_out,
  output logic               out_valid,
  output logic               out_last,
  input  logic               out_ready
);

  state_e             state_q, state_d;
  logic [2:0]         byte_cnt_q, byte_cnt_d;
  logic [BLOCK_W-1:0] data_q, data_d, merged, padded;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;
  logic               pad_pending_q, pad_pending_d;
  logic               accept, out_fire, full_last;

  assign accept    = in_valid && in_ready;
  assign out_fire  = out_valid_q && out_ready;
  assign full_last = (byte_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      byte_cnt_q    <= 3'd0;
      data_q        <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      pad_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      data_q        <= data_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      pad_pending_q <= pad_pending_d;
    end
  end

  // Current block with the incoming byte written into slot byte_cnt_q.
  always_comb begin
    merged = data_q;
    for (int j = 0; j < 8; j++) begin
      if (3'(j) == byte_cnt_q) begin
        merged[BLOCK_W-1-8*j -: 8] = data_in;
      end
    end
  end

  des_pad_fill u_pad_fill (
    .block_i    (merged),
    .last_idx_i (byte_cnt_q),
    .pad_mode_i (PAD_MODE),
    .block_o    (padded)
  );

  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    data_d        = data_q;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    pad_pending_d = pad_pending_q;
    unique case (state_q)
      S_FILL: begin
        if (accept) begin
          data_d = in_last ? padded : merged;
          if (in_last || full_last) begin
            state_d       = S_HOLD;
            byte_cnt_d    = 3'd0;
            out_valid_d   = 1'b1;
            // An aligned PKCS#7 message still owes a full pad block.
            out_last_d    = in_last && !(PAD_MODE && full_last);
            pad_pending_d = in_last && PAD_MODE && full_last;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end
      S_HOLD: begin
        if (out_fire) begin
          if (pad_pending_q) begin
            state_d       = S_EXTRA;
            data_d        = PKCS_FULL_BLOCK;
            out_last_d    = 1'b1;
            pad_pending_d = 1'b0;
          end else begin
            state_d     = S_FILL;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
          end
        end
      end
      S_EXTRA: begin
        if (out_fire) begin
          state_d     = S_FILL;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
        end
      end
      default: state_d = S_FILL;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_FILL);
    data_out  = data_q;
    out_valid = out_valid_q;
    out_last  = out_last_q;
  end

endmodule

// File: tb/tb_des_block_packer.sv
// Directed and randomized-stream bench for des_block_packer in both pad modes.
module tb_des_block_packer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  data_in;
  logic        in_last;
  logic        in_valid_p, in_valid_z;
  logic        ready_dir, ready_rnd, use_rnd;
  logic        out_ready;

  logic        in_ready_p, out_valid_p, out_last_p;
  logic [63:0] data_out_p;
  logic        in_ready_z, out_valid_z, out_last_z;
  logic [63:0] data_out_z;

  int n_checks = 0;
  int n_fail   = 0;

  logic [64:0] got_mem [0:255];
  int          got_wr = 0;
  int          got_rd = 0;
  logic [64:0] exp_q [$];
  logic [7:0]  msg [$];

  always #5 clk = ~clk;

  assign out_ready = use_rnd ? ready_rnd : ready_dir;

  des_block_packer #(.PAD_MODE(1'b1)) u_pkcs (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid_p),
    .in_last   (in_last),
    .in_ready  (in_ready_p),
    .data_out  (data_out_p),
    .out_valid (out_valid_p),
    .out_last  (out_last_p),
    .out_ready (out_ready)
  );

  des_block_packer #(.PAD_MODE(1'b0)) u_zero (
    .clk       (clk),
    .rst_n     (rst_n),
    .data_in   (data_in),
    .in_valid  (in_valid_z),
    .in_last   (in_last),
    .in_ready  (in_ready_z),
    .data_out  (data_out_z),
    .out_valid (out_valid_z),
    .out_last  (out_last_z),
    .out_ready (out_ready)
  );

  always @(posedge clk) ready_rnd <= ($urandom_range(0, 3) != 0);

  // Inputs only change just after posedge, so a negedge view predicts the next handshake.
  always @(negedge clk) begin
    if (rst_n && out_valid_p && out_ready) begin
      got_mem[got_wr[7:0]] <= {out_last_p, data_out_p};
      got_wr               <= got_wr + 1;
    end
  end

  task automatic check64(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check1(input string tag, input logic got, input logic exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte to the selected packer and hold it until accepted.
  task automatic send(input bit sel_zero, input logic [7:0] b, input bit last);
    int  t    = 0;
    bit  done = 1'b0;
    bit  rdy;
    data_in = b;
    in_last = last;
    if (sel_zero) in_valid_z = 1'b1;
    else          in_valid_p = 1'b1;
    while (!done && t < 300) begin
      rdy = sel_zero ? in_ready_z : in_ready_p;
      tick();
      done = rdy;
      t++;
    end
    in_valid_p = 1'b0;
    in_valid_z = 1'b0;
    in_last    = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $error("FAIL send_timeout: byte %h observed not accepted, expected accept", b);
    end
  endtask

  task automatic expect_block(input string tag, input logic [63:0] ed, input logic el);
    int t = 0;
    while (got_wr <= got_rd && t < 400) begin
      tick();
      t++;
    end
    if (got_wr <= got_rd) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: observed no block, expected %h", tag, ed);
    end else begin
      check64({tag, "_data"}, got_mem[got_rd[7:0]][63:0], ed);
      check1({tag, "_last"}, got_mem[got_rd[7:0]][64], el);
      got_rd++;
    end
  endtask

  // Reference PKCS#7 packer for one message held in msg.
  task automatic model_msg();
    int          n = msg.size();
    int          rem;
    logic [63:0] blk;
    logic [7:0]  v;
    for (int i = 0; i < n; i += 8) begin
      rem = n - i;
      blk = '0;
      for (int j = 0; j < 8; j++) begin
        v = (j < rem) ? msg[i+j] : 8'(8 - rem);
        blk[63-8*j -: 8] = v;
      end
      exp_q.push_back({(rem <= 8) && (rem != 8), blk});
    end
    if (n % 8 == 0) exp_q.push_back({1'b1, 64'h0808080808080808});
  endtask

  initial begin
    logic [64:0] e;
    int          len;
    rst_n      = 1'b0;
    data_in    = 8'h00;
    in_last    = 1'b0;
    in_valid_p = 1'b0;
    in_valid_z = 1'b0;
    ready_dir  = 1'b1;
    use_rnd    = 1'b0;
    #12;
    check1("rst_in_ready", in_ready_p, 1'b1);
    check1("rst_out_valid", out_valid_p, 1'b0);
    check1("rst_out_last", out_last_p, 1'b0);
    check64("rst_data_out", data_out_p, 64'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Aligned PKCS#7 message: data block then full pad block.
    for (int i = 1; i <= 8; i++) send(1'b0, 8'(i), i == 8);
    check1("aligned_latency", out_valid_p, 1'b1);
    expect_block("aligned_b0", 64'h0102030405060708, 1'b0);
    expect_block("aligned_b1", 64'h0808080808080808, 1'b1);

    send(1'b0, 8'hAA, 1'b0);
    send(1'b0, 8'hBB, 1'b0);
    send(1'b0, 8'hCC, 1'b1);
    expect_block("pkcs3", 64'hAABBCC0505050505, 1'b1);

    send(1'b1, 8'hAA, 1'b0);
    send(1'b1, 8'hBB, 1'b0);
    send(1'b1, 8'hCC, 1'b1);
    check1("zero3_valid", out_valid_z, 1'b1);
    check64("zero3_data", data_out_z, 64'hAABBCC0000000000);
    check1("zero3_last", out_last_z, 1'b1);
    tick();
    tick();
    check1("zero3_drained", out_valid_z, 1'b0);

    // Back-pressure: first block held for 5 cycles while the next byte waits.
    ready_dir = 1'b0;
    for (int i = 0; i < 8; i++) send(1'b0, 8'(i), 1'b0);
    data_in    = 8'h08;
    in_valid_p = 1'b1;
    for (int c = 0; c < 5; c++) begin
      check1("stall_in_ready", in_ready_p, 1'b0);
      check1("stall_valid", out_valid_p, 1'b1);
      check64("stall_data", data_out_p, 64'h0001020304050607);
      tick();
    end
    ready_dir = 1'b1;
    for (int i = 8; i < 16; i++) send(1'b0, 8'(i), 1'b0);
    expect_block("stall_b0", 64'h0001020304050607, 1'b0);
    expect_block("stall_b1", 64'h08090A0B0C0D0E0F, 1'b0);

    send(1'b0, 8'h41, 1'b1);
    check1("one_latency", out_valid_p, 1'b1);
    expect_block("one_byte", 64'h4107070707070707, 1'b1);

    // Asynchronous reset in the middle of a partial block.
    for (int i = 0; i < 5; i++) send(1'b0, 8'h90 + 8'(i), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check1("arst_valid", out_valid_p, 1'b0);
    check64("arst_data", data_out_p, 64'h0);
    check1("arst_in_ready", in_ready_p, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) send(1'b0, 8'h11 + 8'(i), 1'b0);
    expect_block("post_rst", 64'h1112131415161718, 1'b0);

    // Random messages with random input gaps and random out_ready.
    use_rnd = 1'b1;
    for (int m = 0; m < 6; m++) begin
      len = (m == 0) ? 16 : int'($urandom_range(1, 40));
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(0, 255)));
      model_msg();
      for (int i = 0; i < len; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(1'b0, msg[i], i == len - 1);
      end
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      expect_block("rand", e[63:0], e[64]);
    end
    use_rnd = 1'b0;
    repeat (4) tick();
    check64("no_extra_blocks", 64'(got_wr), 64'(got_rd));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
